// File: rtl/rv_pkg.sv
// Shared register-file write types and defaults for the write-back arbiter.
package rv_pkg;

  // One register-file write: enable, destination register, data.
  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } rf_wr_req_t;

  // Default depth of the long-latency result buffer.
  localparam int RF_WR_ARB_BUF_DEPTH = 2;

  // Default number of denied cycles before the buffer head is forced through.
  localparam int RF_WR_ARB_STARVE_MAX = 4;

endpackage

// File: rtl/rf_wr_fifo.sv
// Synchronous FIFO holding long-latency results that lost the write port.
// Also reports a one-hot mask of the destinations currently held, so the
// hazard unit can see which registers still have a write outstanding.
module rf_wr_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = RF_WR_ARB_BUF_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  rf_wr_req_t  push_data,
  output rf_wr_req_t  head,
  output logic        full,
  output logic        empty,
  output logic [31:0] pend_mask
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  rf_wr_req_t      mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage is deliberately left unreset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Build the pending-destination mask from the occupied entries only.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count) pend_mask[mem[rd_ptr + PW'(i)].rd] = 1'b1;
    end
    pend_mask[0] = 1'b0;
  end

endmodule

// File: rtl/rf_wr_arb.sv
// Register-file write-port arbiter between pipeline write-back and a
// long-latency (mul/div) unit. Results that cannot use the port are queued.
// Optional anti-starvation drain is enabled by defining RF_WR_ARB_STARVE_EN.
module rf_wr_arb
  import rv_pkg::*;
#(
  parameter int BUF_DEPTH  = RF_WR_ARB_BUF_DEPTH,
  parameter int STARVE_MAX = RF_WR_ARB_STARVE_MAX
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wb_we,
  input  logic [4:0]  i_wb_rd,
  input  logic [31:0] i_wb_data,
  input  logic        i_lu_valid,
  input  logic [4:0]  i_lu_rd,
  input  logic [31:0] i_lu_data,
  output logic        o_lu_ready,
  output logic        o_rf_we,
  output logic [4:0]  o_rf_rd,
  output logic [31:0] o_rf_data,
  output logic        o_stall,
  output logic [31:0] o_pend_mask
);

  rf_wr_req_t head;
  rf_wr_req_t push_data;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic       bypass;
  logic       rf_we;
  logic       wb_req;
  logic       lu_acc;
  logic       head_live;
  logic       force_drain;

  // x0 writes are architecturally discarded, so they never claim the port.
  assign wb_req    = i_wb_we && (i_wb_rd != 5'd0);
  assign lu_acc    = i_lu_valid && o_lu_ready;
  assign head_live = head.we && (head.rd != 5'd0);
  assign push_data = '{we: 1'b1, rd: i_lu_rd, data: i_lu_data};

  // A full buffer never refills in the same cycle it drains, keeping ready a pure function of occupancy.
  assign o_lu_ready = !full && !i_rst;
  assign o_rf_we    = rf_we && !i_rst;

`ifdef RF_WR_ARB_STARVE_EN
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_cnt;

  assign force_drain = !empty && (starve_cnt == SW'(STARVE_MAX));
  assign o_stall     = force_drain && !i_rst;

  // Count cycles the queued head is held off by the pipeline; any pop or empty buffer restarts it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      starve_cnt <= '0;
    end else if (empty || pop) begin
      starve_cnt <= '0;
    end else if (wb_req) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end
`else
  assign force_drain = 1'b0;
  assign o_stall     = 1'b0;
`endif

  // Port grant: forced drain, then pipeline, then buffer head, then direct bypass.
  always_comb begin
    rf_we     = 1'b0;
    o_rf_rd   = 5'd0;
    o_rf_data = 32'd0;
    pop       = 1'b0;
    bypass    = 1'b0;
    if (force_drain) begin
      pop = 1'b1;
      if (head_live) begin
        rf_we     = 1'b1;
        o_rf_rd   = head.rd;
        o_rf_data = head.data;
      end
    end else if (wb_req) begin
      rf_we     = 1'b1;
      o_rf_rd   = i_wb_rd;
      o_rf_data = i_wb_data;
    end else if (!empty) begin
      pop = 1'b1;
      if (head_live) begin
        rf_we     = 1'b1;
        o_rf_rd   = head.rd;
        o_rf_data = head.data;
      end
    end else if (lu_acc && (i_lu_rd != 5'd0)) begin
      bypass    = 1'b1;
      rf_we     = 1'b1;
      o_rf_rd   = i_lu_rd;
      o_rf_data = i_lu_data;
    end
    if (!empty && !head_live) pop = 1'b1;
    push = lu_acc && (i_lu_rd != 5'd0) && !bypass;
  end

  rf_wr_fifo #(
    .DEPTH(BUF_DEPTH)
  ) u_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .pend_mask (o_pend_mask)
  );

endmodule

// File: tb/tb_rf_wr_arb.sv
// Directed self-checking bench for rf_wr_arb with default parameters.
// Starvation expectations follow whether RF_WR_ARB_STARVE_EN is defined.
module tb_rf_wr_arb;

  logic        clk;
  logic        i_rst;
  logic        i_wb_we;
  logic [4:0]  i_wb_rd;
  logic [31:0] i_wb_data;
  logic        i_lu_valid;
  logic [4:0]  i_lu_rd;
  logic [31:0] i_lu_data;
  logic        o_lu_ready;
  logic        o_rf_we;
  logic [4:0]  o_rf_rd;
  logic [31:0] o_rf_data;
  logic        o_stall;
  logic [31:0] o_pend_mask;

  int n_checks = 0;
  int n_fails  = 0;

  rf_wr_arb dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_wb_we     (i_wb_we),
    .i_wb_rd     (i_wb_rd),
    .i_wb_data   (i_wb_data),
    .i_lu_valid  (i_lu_valid),
    .i_lu_rd     (i_lu_rd),
    .i_lu_data   (i_lu_data),
    .o_lu_ready  (o_lu_ready),
    .o_rf_we     (o_rf_we),
    .o_rf_rd     (o_rf_rd),
    .o_rf_data   (o_rf_data),
    .o_stall     (o_stall),
    .o_pend_mask (o_pend_mask)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, then let outputs settle.
  task automatic applyStimulus(input logic wb_we, input logic [4:0] wb_rd, input logic [31:0] wb_data,
                               input logic lu_valid, input logic [4:0] lu_rd, input logic [31:0] lu_data);
    @(negedge clk);
    i_wb_we    = wb_we;
    i_wb_rd    = wb_rd;
    i_wb_data  = wb_data;
    i_lu_valid = lu_valid;
    i_lu_rd    = lu_rd;
    i_lu_data  = lu_data;
    #1;
  endtask

  initial begin
    i_rst      = 1'b1;
    i_wb_we    = 1'b0;
    i_wb_rd    = 5'd0;
    i_wb_data  = 32'd0;
    i_lu_valid = 1'b0;
    i_lu_rd    = 5'd0;
    i_lu_data  = 32'd0;
    #1;
    checkOutput("rst_rf_we", o_rf_we, 0);
    checkOutput("rst_stall", o_stall, 0);
    checkOutput("rst_ready", o_lu_ready, 0);
    checkOutput("rst_mask", o_pend_mask, 0);
    @(negedge clk);
    i_rst = 1'b0;

    // Pipeline-only write
    applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0);
    checkOutput("pipe_we", o_rf_we, 1);
    checkOutput("pipe_rd", o_rf_rd, 5);
    checkOutput("pipe_data", o_rf_data, 32'hDEADBEEF);
    checkOutput("pipe_ready", o_lu_ready, 1);
    checkOutput("pipe_stall", o_stall, 0);

    // Bypass of an idle port
    applyStimulus(0, 0, 0, 1, 7, 32'h12);
    checkOutput("byp_we", o_rf_we, 1);
    checkOutput("byp_rd", o_rf_rd, 7);
    checkOutput("byp_data", o_rf_data, 32'h12);
    checkOutput("byp_mask", o_pend_mask, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("byp_after_mask", o_pend_mask, 0);
    checkOutput("byp_after_we", o_rf_we, 0);

    // Contention: two results buffered behind the pipeline
    applyStimulus(1, 10, 32'hA, 1, 3, 32'h33);
    checkOutput("cont1_rd", o_rf_rd, 10);
    checkOutput("cont1_ready", o_lu_ready, 1);
    applyStimulus(1, 11, 32'hB, 1, 4, 32'h44);
    checkOutput("cont2_rd", o_rf_rd, 11);
    checkOutput("cont2_mask", o_pend_mask, 32'h08);
    applyStimulus(1, 12, 32'hC, 0, 0, 0);
    checkOutput("cont3_rd", o_rf_rd, 12);
    checkOutput("cont3_mask", o_pend_mask, 32'h18);
    checkOutput("cont3_ready", o_lu_ready, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("drain1_we", o_rf_we, 1);
    checkOutput("drain1_rd", o_rf_rd, 3);
    checkOutput("drain1_data", o_rf_data, 32'h33);
    checkOutput("drain1_ready", o_lu_ready, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("drain2_rd", o_rf_rd, 4);
    checkOutput("drain2_data", o_rf_data, 32'h44);
    checkOutput("drain2_mask", o_pend_mask, 32'h10);
    checkOutput("drain2_ready", o_lu_ready, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("drained_we", o_rf_we, 0);
    checkOutput("drained_mask", o_pend_mask, 0);

    // x0 handling
    applyStimulus(0, 0, 0, 1, 0, 32'h99);
    checkOutput("x0lu_ready", o_lu_ready, 1);
    checkOutput("x0lu_we", o_rf_we, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("x0lu_mask", o_pend_mask, 0);
    checkOutput("x0lu_after_we", o_rf_we, 0);
    applyStimulus(1, 13, 32'hD, 1, 6, 32'h66);
    checkOutput("x0buf_rd", o_rf_rd, 13);
    applyStimulus(1, 0, 32'hE, 0, 0, 0);
    checkOutput("x0wb_we", o_rf_we, 1);
    checkOutput("x0wb_rd", o_rf_rd, 6);
    checkOutput("x0wb_data", o_rf_data, 32'h66);
    applyStimulus(1, 0, 32'hF, 0, 0, 0);
    checkOutput("x0wb_empty_we", o_rf_we, 0);
    checkOutput("x0wb_empty_mask", o_pend_mask, 0);

    // Starvation: rd=9 queued behind a continuously writing pipeline
    applyStimulus(1, 20, 32'h20, 1, 9, 32'h99);
    checkOutput("starve_push_rd", o_rf_rd, 20);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1, 5'(20 + k), 32'(k), 0, 0, 0);
      checkOutput("starve_wait_rd", o_rf_rd, 32'(20 + k));
      checkOutput("starve_wait_stall", o_stall, 0);
      checkOutput("starve_wait_mask", o_pend_mask, 32'h200);
    end
    applyStimulus(1, 30, 32'h30, 0, 0, 0);
`ifdef RF_WR_ARB_STARVE_EN
    checkOutput("starve_stall", o_stall, 1);
    checkOutput("starve_rd", o_rf_rd, 9);
    checkOutput("starve_data", o_rf_data, 32'h99);
    applyStimulus(1, 30, 32'h30, 0, 0, 0);
    checkOutput("starve_held_stall", o_stall, 0);
    checkOutput("starve_held_rd", o_rf_rd, 30);
    checkOutput("starve_held_data", o_rf_data, 32'h30);
    checkOutput("starve_held_mask", o_pend_mask, 0);
`else
    checkOutput("nostarve_stall", o_stall, 0);
    checkOutput("nostarve_rd", o_rf_rd, 30);
    checkOutput("nostarve_mask", o_pend_mask, 32'h200);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("nostarve_drain_rd", o_rf_rd, 9);
    checkOutput("nostarve_drain_stall", o_stall, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("nostarve_done_mask", o_pend_mask, 0);
`endif

    // Reset mid-operation discards the buffered results
    applyStimulus(1, 14, 32'h14, 1, 1, 32'h11);
    applyStimulus(1, 15, 32'h15, 1, 2, 32'h22);
    checkOutput("prerst_mask", o_pend_mask, 32'h02);
    @(negedge clk);
    i_rst      = 1'b1;
    i_wb_we    = 1'b0;
    i_lu_valid = 1'b0;
    #1;
    checkOutput("midrst_we", o_rf_we, 0);
    checkOutput("midrst_mask", o_pend_mask, 0);
    checkOutput("midrst_ready", o_lu_ready, 0);
    @(negedge clk);
    i_rst = 1'b0;
    #1;
    checkOutput("postrst_ready", o_lu_ready, 1);
    checkOutput("postrst_we", o_rf_we, 0);
    checkOutput("postrst_mask", o_pend_mask, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/rf_wr_arb.md
RF_WR_ARB -- requirements
Module: rf_wr_arb

Interface
REQ-001 Parameter BUF_DEPTH, default 2: number of entries in the long-latency result buffer (power of two, 2..8).
REQ-002 Parameter STARVE_MAX, default 4: consecutive denied cycles before the buffer head is forced through (REQ-019).
REQ-003 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  asynchronous, active-high reset.
REQ-005 i_wb_we / i_wb_rd / i_wb_data  input  1/5/32  pipeline write-back request (write enable, destination register, data).
REQ-006 i_lu_valid / i_lu_rd / i_lu_data  input  1/5/32  long-latency unit result (mul/div) offered for write-back.
REQ-007 o_lu_ready  output  1  result accepted this cycle when i_lu_valid && o_lu_ready.
REQ-008 o_rf_we / o_rf_rd / o_rf_data  output  1/5/32  single register-file write port.
REQ-009 o_stall  output  1  freeze pipeline (MEM/WB held) this cycle.
REQ-010 o_pend_mask  output  32  one-hot OR of rd of all valid buffer entries, for the hazard unit; bit 0 always 0.

Function
REQ-011 Port grant priority, evaluated combinationally each cycle: forced drain (REQ-019) > pipeline (i_wb_we, rd != 0) > buffer head > direct bypass of long-latency unit.
REQ-012 Pipeline grant: o_rf_we=1, o_rf_rd=i_wb_rd, o_rf_data=i_wb_data, zero added latency.
REQ-013 Buffer drain: when the pipeline does not use the port and buffer is non-empty, head is written and popped the same cycle.
REQ-014 Bypass: buffer empty, port free, i_lu_valid=1 -> result written directly same cycle, not pushed.
REQ-015 Otherwise an accepted result is pushed at the tail; FIFO order preserved; push and pop in the same cycle are both performed.
REQ-016 o_lu_ready = buffer not full; on full, ready=0 even if a pop occurs that cycle (no same-cycle refill of a full buffer).
REQ-017 Writes with rd=0 never assert o_rf_we; an rd=0 buffer head is popped without a write and does not consume the port; an rd=0 result is accepted and discarded, never pushed.
REQ-018 Pointers wrap modulo BUF_DEPTH; count is ceil(log2(BUF_DEPTH))+1 bits; full = count==BUF_DEPTH, empty = count==0.

Reset
REQ-020 While i_rst=1: buffer empty, pointers/count/starve counter 0, o_rf_we=0, o_stall=0, o_lu_ready=0, o_pend_mask=0; buffer data storage need not be reset.
REQ-021 Reset asserted mid-operation discards buffered results without writing them; first cycle after release o_lu_ready=1.

Configuration
REQ-019 Macro RF_WR_ARB_STARVE_EN defined: starve counter increments each cycle the buffer is non-empty and the pipeline holds the port, clears on any pop or when empty; when counter == STARVE_MAX, o_stall=1 that cycle, buffer head is written instead of the pipeline request, counter clears.
REQ-022 Macro RF_WR_ARB_STARVE_EN undefined: no starve counter; o_stall tied 0; buffer drains only in free port slots; backpressure via o_lu_ready only.

Structure
REQ-023 Request struct rf_wr_req_t {we, rd[4:0], data[31:0]} and RF_WR_ARB_BUF_DEPTH default constant in rv_pkg.
REQ-024 One sub-module rf_wr_fifo (synchronous FIFO, BUF_DEPTH entries, push/pop/full/empty/head); arbitration and starve logic in rf_wr_arb.

Verification
REQ-025 Pipeline only: i_wb_we=1, rd=5, data=0xDEADBEEF, no lu -> o_rf_we=1, rd=5, data=0xDEADBEEF same cycle, o_lu_ready=1.
REQ-026 Bypass: idle pipeline, lu rd=7 data=0x12 -> written same cycle, o_pend_mask=0.
REQ-027 Contention: pipeline writes every cycle, lu offers rd=3 then rd=4 -> both buffered, o_pend_mask=0x18, o_lu_ready=0 (full); pipeline idles -> rd=3 then rd=4 written on consecutive cycles, mask returns 0.
REQ-028 x0: lu rd=0 accepted, no write; pipeline rd=0 with buffer non-empty -> buffer head written that cycle.
REQ-029 Starvation (RF_WR_ARB_STARVE_EN, STARVE_MAX=4): buffer holds rd=9, pipeline writes continuously -> cycle 5 o_stall=1, rd=9 written, pipeline request held and written next cycle; without macro o_stall stays 0.
REQ-030 Reset mid-operation: two entries buffered, pulse i_rst -> no o_rf_we, o_pend_mask=0, o_lu_ready=0 during reset, 1 after.
